// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: registered in_ready, outputs driven straight from the main entry.
// Optional stall counter enabled with `define PIPE_SKID_PERF_EN (adds the stall_cnt port).
module pipe_skid_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    if (WIDTH < 1 || WIDTH > 128 || CNT_W < 1) begin : g_bad_param
        $error("pipe_skid_reg: WIDTH must be 1..128 and CNT_W at least 1");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic             in_ready_q, in_ready_d;
    logic             in_xfer, out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = main_vld_q && out_ready;

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            state_d    = ST_EMPTY;
            main_d     = RESET_VAL;
            skid_d     = RESET_VAL;
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_d     = in_data;
                        main_vld_d = 1'b1;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_d     = in_data;
                        skid_vld_d = 1'b1;
                        state_d    = ST_FULL;
                    end else if (out_xfer && !in_xfer) begin
                        main_vld_d = 1'b0;
                        state_d    = ST_EMPTY;
                    end else if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        main_d     = skid_q;
                        skid_vld_d = 1'b0;
                        state_d    = ST_ONE;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                end
            endcase
        end
        // in_ready is a register: the next cycle accepts only if the skid slot will be free
        in_ready_d = !skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_data  = main_q;
    assign out_valid = main_vld_q;
    assign in_ready  = in_ready_q;

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating; survives flush so stalls across mispredicts stay visible
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (main_vld_q && !out_ready && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed stimulus pushes expected words, a negedge monitor pops them.
// Define PIPE_SKID_PERF_EN to also exercise the stall counter.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
`ifdef PIPE_SKID_PERF_EN
    logic [3:0]  stall_cnt;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .WIDTH(32),
        .RESET_VAL(32'hDEAD_BEEF),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Inputs only change #1 after posedge, so negedge values are what the next edge will see
    always @(negedge clk) begin
        if (!reset && !flush && out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got 0x%08h expected no output", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit expect_out);
        in_valid = 1'b1;
        in_data  = d;
        if (expect_out) exp_q.push_back(d);
        step();
    endtask

    initial begin
        bit got_ready;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'hDEAD_BEEF);

        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            send(i, 1'b1);
            if (i == 1) begin
                chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
                chk("latency_out_data", out_data, 32'd1);
            end
        end
        in_valid = 1'b0;
        repeat (2) step();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // back-pressure
        out_ready = 1'b0;
        send(32'd10, 1'b1);
        send(32'd11, 1'b1);
        @(negedge clk);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_main_holds", out_data, 32'd10);
        in_data = 32'd12;
        exp_q.push_back(32'd12);
        repeat (2) step();
        chk("bp_still_full", {31'd0, in_ready}, 32'd0);
        chk("bp_main_unchanged", out_data, 32'd10);
        out_ready = 1'b1;
        got_ready = 1'b0;
        for (int k = 0; k < 8 && !got_ready; k++) begin
            @(negedge clk);
            if (in_ready) got_ready = 1'b1;
        end
        chk("bp_ready_returns", {31'd0, got_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // flush while FULL, with 7 offered in the same cycle
        out_ready = 1'b0;
        send(32'd5, 1'b0);
        send(32'd6, 1'b0);
        in_data = 32'd7;
        flush   = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_out_data", out_data, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        repeat (3) step();
        chk("flush_nothing_out", {31'd0, out_valid}, 32'd0);

        // reset and flush together while FULL
        out_ready = 1'b0;
        send(32'd8, 1'b0);
        send(32'd9, 1'b0);
        chk("pre_reset_full", {31'd0, in_ready}, 32'd0);
        in_data = 32'h77; reset = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rstpri_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstpri_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstpri_out_data", out_data, 32'hDEAD_BEEF);
`ifdef PIPE_SKID_PERF_EN
        chk("rstpri_stall_cnt", {28'd0, stall_cnt}, 32'd0);
`endif

        // single entry held under back-pressure
        send(32'd99, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_out_data", out_data, 32'd99);
`ifdef PIPE_SKID_PERF_EN
        repeat (20) step();
        chk("stall_saturated", {28'd0, stall_cnt}, 32'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("stall_kept_by_flush", {28'd0, stall_cnt}, 32'd15);
        chk("perf_flush_out_valid", {31'd0, out_valid}, 32'd0);
`else
        repeat (3) step();
        chk("hold_data_stable", out_data, 32'd99);
`endif
        out_ready = 1'b1;
        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
